serial_rx: RTL and testbench

- Receiver for the one-bit-per-clock serial link driven by the team's 8-bit serial transmitter; sits directly downstream and consumes its txd line.
- Line format, one bit per clk cycle with no baud divider:
  - idle low;
  - start bit = 1;
  - DATA_W data bits, LSB first;
  - stop bit = 0.
- Deframes each frame into a parallel word. The word is held in an output register behind a valid/ready handshake, with frame-error and overrun flags.

---
 rtl/serial_rx.sv | 122 ++++++++++++
 tb/tb_serial_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Deframing receiver for the one-bit-per-clock serial link (idle 0, start 1, LSB-first data, stop 0).
// Completed words sit in an output register behind a valid/ready handshake with error/overrun pulses.
module serial_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_RESYNC
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                ferr_q, ferr_d;
    logic                ovr_q, ovr_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // A read with nothing new arriving empties the output register.
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rxd) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                shift_d[cnt_q] = rxd;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (!rxd) begin
                    state_d = S_IDLE;
                    // A simultaneous read frees the register for the new word.
                    if (!valid_q || rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    ferr_d  = 1'b1;
                    state_d = S_RESYNC;
                end
            end
            S_RESYNC: begin
                // Hold off until the line returns low so a stuck-high rxd cannot start frames.
                if (!rxd) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the shift register is
    // reset too, since it is small and its contents are architecturally visible on commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: frames are scheduled up front with their expected events, then replayed
// edge by edge against a handshake model; literal checks pin the directed scenarios.
module tb_serial_rx;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;
    localparam int N      = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              rxd;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    always #5 clk = ~clk;

    serial_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Schedule: value on rxd / rx_ready at edge k, and what the line protocol implies after edge k.
    bit          rxd_seq   [N];
    bit          ready_seq [N];
    bit          busy_e    [N];
    bit          commit_v  [N];
    logic [7:0]  commit_d  [N];
    bit          ferr_e    [N];
    logic        obs_valid [N];
    logic        obs_busy  [N];
    logic        obs_ferr  [N];
    logic        obs_ovr   [N];
    logic [7:0]  obs_data  [N];
    int          len = 0;

    int          checks = 0;
    int          errors = 0;

    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_ferr;
    logic        exp_ovr;

    int a_start, b_start, c_start, c_rd, d_start, e_start, e2_start;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // r: 0/1 fixed rx_ready, 2 = random
    task automatic push(input bit b, input int r, input bit bz);
        rxd_seq[len]   = b;
        ready_seq[len] = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
        busy_e[len]    = bz;
        commit_v[len]  = 1'b0;
        commit_d[len]  = 8'h00;
        ferr_e[len]    = 1'b0;
        len++;
    endtask

    task automatic add_idle(input int n, input int r);
        for (int i = 0; i < n; i++) push(1'b0, r, 1'b0);
    endtask

    task automatic add_frame(input logic [7:0] d, input bit good, input int hold, input int r);
        push(1'b1, r, 1'b1);
        for (int i = 0; i < DATA_W; i++) push(d[i], r, 1'b1);
        if (good) begin
            push(1'b0, r, 1'b0);
            commit_v[len-1] = 1'b1;
            commit_d[len-1] = d;
        end else begin
            push(1'b1, r, 1'b1);
            ferr_e[len-1] = 1'b1;
            for (int i = 0; i < hold; i++) push(1'b1, r, 1'b1);
            push(1'b0, r, 1'b0);
        end
    endtask

    task automatic drive_bit(input bit b, input bit r);
        rxd      = b;
        rx_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rx_data"},   32'(rx_data),   32'h0);
        check({tag, " rx_valid"},  32'(rx_valid),  32'h0);
        check({tag, " busy"},      32'(busy),      32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
        check({tag, " overrun"},   32'(overrun),   32'h0);
    endtask

    initial begin
        logic [7:0] fr;
        int first_v;

        rst      = 1'b0;
        rxd      = 1'b0;
        rx_ready = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Directed scenarios
        add_idle(2, 1);
        a_start = len;
        add_frame(8'hA5, 1'b1, 0, 1);
        add_idle(3, 1);

        b_start = len;
        add_frame(8'h3C, 1'b1, 0, 1);
        add_frame(8'hFF, 1'b1, 0, 1);
        add_idle(2, 1);

        add_idle(1, 0);
        c_start = len;
        add_frame(8'h12, 1'b1, 0, 0);
        add_frame(8'h34, 1'b1, 0, 0);
        add_idle(2, 0);
        c_rd = len;
        add_idle(3, 1);

        add_frame(8'h55, 1'b1, 0, 0);
        add_idle(1, 0);
        d_start = len;
        add_frame(8'hAA, 1'b1, 0, 0);
        ready_seq[len-1] = 1'b1;
        add_idle(2, 1);

        add_idle(1, 1);
        e_start = len;
        add_frame(8'h00, 1'b0, 5, 1);
        add_idle(1, 1);
        e2_start = len;
        add_frame(8'h81, 1'b1, 0, 1);
        add_idle(2, 1);

        // Random traffic: mixed gaps, good/bad frames, stuck-high holds, random rx_ready
        while (len < N - 40) begin
            add_idle($urandom_range(0, 3), 2);
            add_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 4), 2);
        end
        add_idle(2, 2);

        exp_valid = 1'b0;
        exp_data  = 8'h00;
        for (int k = 0; k < len; k++) begin
            rxd      = rxd_seq[k];
            rx_ready = ready_seq[k];
            @(posedge clk);
            #2;
            exp_ferr = ferr_e[k];
            exp_ovr  = 1'b0;
            if (commit_v[k]) begin
                if (!exp_valid || ready_seq[k]) begin
                    exp_data  = commit_d[k];
                    exp_valid = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (exp_valid && ready_seq[k]) begin
                exp_valid = 1'b0;
            end
            check($sformatf("rx_valid@%0d", k),  32'(rx_valid),  32'(exp_valid));
            check($sformatf("rx_data@%0d", k),   32'(rx_data),   32'(exp_data));
            check($sformatf("busy@%0d", k),      32'(busy),      32'(busy_e[k]));
            check($sformatf("frame_err@%0d", k), 32'(frame_err), 32'(exp_ferr));
            check($sformatf("overrun@%0d", k),   32'(overrun),   32'(exp_ovr));
            obs_valid[k] = rx_valid;
            obs_data[k]  = rx_data;
            obs_busy[k]  = busy;
            obs_ferr[k]  = frame_err;
            obs_ovr[k]   = overrun;
        end

        // Hand-computed pins on the directed scenarios
        first_v = -1;
        for (int k = a_start; k < a_start + 14; k++) begin
            if (obs_valid[k] === 1'b1 && first_v < 0) first_v = k;
        end
        check("single latency",      32'(first_v - a_start),      32'd9);
        check("single data",         32'(obs_data[a_start + 9]),  32'hA5);
        check("single valid pulse",  32'(obs_valid[a_start + 10]), 32'h0);
        check("single busy before",  32'(obs_busy[a_start - 1]),  32'h0);
        check("single busy first",   32'(obs_busy[a_start]),      32'h1);
        check("single busy last",    32'(obs_busy[a_start + 8]),  32'h1);
        check("single busy end",     32'(obs_busy[a_start + 9]),  32'h0);

        check("b2b first data",      32'(obs_data[b_start + 9]),  32'h3C);
        check("b2b first valid",     32'(obs_valid[b_start + 9]), 32'h1);
        check("b2b second data",     32'(obs_data[b_start + 19]), 32'hFF);
        check("b2b second valid",    32'(obs_valid[b_start + 19]), 32'h1);
        check("b2b gap valid",       32'(obs_valid[b_start + 18]), 32'h0);

        check("overrun data",        32'(obs_data[c_start + 19]), 32'h12);
        check("overrun valid",       32'(obs_valid[c_start + 19]), 32'h1);
        check("overrun pulse",       32'(obs_ovr[c_start + 19]),  32'h1);
        check("overrun one shot",    32'(obs_ovr[c_start + 20]),  32'h0);
        check("overrun read drop",   32'(obs_valid[c_rd]),        32'h0);

        check("same-cycle before",   32'(obs_data[d_start + 8]),  32'h55);
        check("same-cycle data",     32'(obs_data[d_start + 9]),  32'hAA);
        check("same-cycle valid",    32'(obs_valid[d_start + 9]), 32'h1);
        check("same-cycle no ovr",   32'(obs_ovr[d_start + 9]),   32'h0);

        check("ferr pulse",          32'(obs_ferr[e_start + 9]),  32'h1);
        check("ferr one shot",       32'(obs_ferr[e_start + 10]), 32'h0);
        check("ferr no valid",       32'(obs_valid[e_start + 9]), 32'h0);
        check("ferr busy in hold",   32'(obs_busy[e_start + 14]), 32'h1);
        check("ferr busy released",  32'(obs_busy[e_start + 15]), 32'h0);
        check("ferr next data",      32'(obs_data[e2_start + 9]), 32'h81);

        // Reset in the middle of a frame, with a word pending in the output register
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b1);
        fr = 8'hC3;
        drive_bit(1'b1, 1'b0);
        for (int i = 0; i < DATA_W; i++) drive_bit(fr[i], 1'b0);
        drive_bit(1'b0, 1'b0);
        check("pre-reset valid", 32'(rx_valid), 32'h1);
        check("pre-reset data",  32'(rx_data),  32'hC3);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        check("pre-reset busy",  32'(busy),     32'h1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async reset");
        rxd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b0, 1'b1);
            check($sformatf("post-reset idle busy %0d", i),  32'(busy),     32'h0);
            check($sformatf("post-reset idle valid %0d", i), 32'(rx_valid), 32'h0);
        end
        fr = 8'h5A;
        drive_bit(1'b1, 1'b1);
        for (int i = 0; i < DATA_W; i++) drive_bit(fr[i], 1'b1);
        drive_bit(1'b0, 1'b1);
        check("post-reset valid", 32'(rx_valid),  32'h1);
        check("post-reset data",  32'(rx_data),   32'h5A);
        check("post-reset ferr",  32'(frame_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
